// File: rtl/pinwheel_operand_fetch_if.sv
// ============================================================================
//  Module      : pinwheel_operand_fetch_if
//  Description : Bundles the signals of the pinwheel operand-fetch stage:
//                the decode-side request handshake, the regfile read ports,
//                the regfile write-port snoop and the execute-side operand
//                handshake.
//                  in_valid/in_ready/in_hart/in_rs1/in_rs2/in_tag : request
//                  raddr0/raddr1, rdata0/rdata1                    : RAM reads
//                  wb_wren/wb_waddr/wb_wdata                       : write snoop
//                  out_valid/out_ready/out_hart/out_tag/
//                  out_rs1_data/out_rs2_data                       : operands
//                slave  = view of the operand-fetch block itself
//                master = view of its surroundings (decode, regfile, execute)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pinwheel_operand_fetch_if #(
  parameter int TAG_WIDTH = 32,
  parameter int HART_BITS = 2
);
  // Request from decode
  logic                 in_valid;
  logic                 in_ready;
  logic [HART_BITS-1:0] in_hart;
  logic [4:0]           in_rs1;
  logic [4:0]           in_rs2;
  logic [TAG_WIDTH-1:0] in_tag;

  // Regfile read ports (registered RAM, 1-cycle latency)
  logic [7:0]           raddr0;
  logic [7:0]           raddr1;
  logic [31:0]          rdata0;
  logic [31:0]          rdata1;

  // Regfile write port snoop
  logic                 wb_wren;
  logic [7:0]           wb_waddr;
  logic [31:0]          wb_wdata;

  // Operands to execute
  logic                 out_valid;
  logic                 out_ready;
  logic [HART_BITS-1:0] out_hart;
  logic [TAG_WIDTH-1:0] out_tag;
  logic [31:0]          out_rs1_data;
  logic [31:0]          out_rs2_data;

  modport slave (
    input  in_valid, in_hart, in_rs1, in_rs2, in_tag,
    output in_ready,
    output raddr0, raddr1,
    input  rdata0, rdata1,
    input  wb_wren, wb_waddr, wb_wdata,
    output out_valid, out_hart, out_tag, out_rs1_data, out_rs2_data,
    input  out_ready
  );

  modport master (
    output in_valid, in_hart, in_rs1, in_rs2, in_tag,
    input  in_ready,
    input  raddr0, raddr1,
    output rdata0, rdata1,
    output wb_wren, wb_waddr, wb_wdata,
    input  out_valid, out_hart, out_tag, out_rs1_data, out_rs2_data,
    output out_ready
  );
endinterface

`default_nettype wire

// File: rtl/pinwheel_operand_fetch.sv
// ============================================================================
//  Module      : pinwheel_operand_fetch
//  Description : Register-read stage between decode and execute. Issues reads
//                to a registered block-RAM regfile, then returns hazard-free
//                operands through a valid/ready output. Regfile writes are
//                snooped so operands in flight or held in the output register
//                always reflect every write made before they are consumed.
//  Ports       : clk  - clock, all state on posedge
//                rst  - synchronous reset, active-high
//                bus  - pinwheel_operand_fetch_if.slave
//                       request in, RAM read addr/data, write snoop,
//                       operands out
//  Parameters  : TAG_WIDTH - width of the opaque payload carried alongside
//                HART_BITS - hart index width (HART_BITS + 5 <= 8)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pinwheel_operand_fetch #(
  parameter int TAG_WIDTH = 32,
  parameter int HART_BITS = 2
) (
  input  wire logic               clk,
  input  wire logic               rst,
  pinwheel_operand_fetch_if.slave bus
);

  localparam int REG_BITS  = 5;
  localparam int ADDR_BITS = 8;
  localparam int NUM_OPND  = 2;

  // Regfile address = {zero pad, hart, reg}
  function automatic logic [ADDR_BITS-1:0] reg_addr(
    input logic [HART_BITS-1:0] hart,
    input logic [REG_BITS-1:0]  rs
  );
    logic [ADDR_BITS-1:0] a;
    a = '0;
    a[HART_BITS+REG_BITS-1:0] = {hart, rs};
    return a;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  // S1: read in flight in the RAM
  logic                 s1_valid;
  logic [HART_BITS-1:0] s1_hart;
  logic [TAG_WIDTH-1:0] s1_tag;
  logic [REG_BITS-1:0]  s1_rs    [NUM_OPND];
  logic                 byp_hit  [NUM_OPND];
  logic [31:0]          byp_data [NUM_OPND];

  // OUT: operand register presented to execute
  logic                 out_valid;
  logic [HART_BITS-1:0] out_hart;
  logic [TAG_WIDTH-1:0] out_tag;
  logic [REG_BITS-1:0]  out_rs   [NUM_OPND];
  logic [31:0]          out_data [NUM_OPND];

  // Last issued read address, replayed while the stage sits idle
  logic [ADDR_BITS-1:0] raddr_last [NUM_OPND];

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic adv;
  logic in_ready;
  logic accept;
  logic s1_move;

  assign adv      = !out_valid || bus.out_ready;
  assign in_ready = !s1_valid || adv;
  assign accept   = bus.in_valid && in_ready;
  assign s1_move  = s1_valid && adv;

  // A RAM read is issued for the S1 occupant (new or stalled) this cycle
  logic read_cycle;
  assign read_cycle = accept || s1_valid;

  // --------------------------------------------------------------------------
  // Per-operand address and data selection
  // --------------------------------------------------------------------------
  logic [REG_BITS-1:0]  in_rs      [NUM_OPND];
  logic [31:0]          rdata      [NUM_OPND];
  logic [ADDR_BITS-1:0] raddr      [NUM_OPND];
  logic [ADDR_BITS-1:0] s1_addr    [NUM_OPND];
  logic [ADDR_BITS-1:0] out_addr   [NUM_OPND];
  logic                 wb_hit_rd  [NUM_OPND];
  logic                 wb_hit_s1  [NUM_OPND];
  logic                 wb_hit_out [NUM_OPND];
  logic [31:0]          load_data  [NUM_OPND];

  assign in_rs[0] = bus.in_rs1;
  assign in_rs[1] = bus.in_rs2;
  assign rdata[0] = bus.rdata0;
  assign rdata[1] = bus.rdata1;

  generate
    for (genvar i = 0; i < NUM_OPND; i++) begin : g_opnd
      assign s1_addr[i]  = reg_addr(s1_hart, s1_rs[i]);
      assign out_addr[i] = reg_addr(out_hart, out_rs[i]);

      // A stalled S1 keeps re-reading its own address so rdata stays current
      assign raddr[i] = accept   ? reg_addr(bus.in_hart, in_rs[i]) :
                        s1_valid ? s1_addr[i] :
                                   raddr_last[i];

      // The RAM returns old data on a same-address write; remember it
      assign wb_hit_rd[i]  = bus.wb_wren && (bus.wb_waddr == raddr[i]);
      assign wb_hit_s1[i]  = bus.wb_wren && (bus.wb_waddr == s1_addr[i]);
      assign wb_hit_out[i] = bus.wb_wren && (bus.wb_waddr == out_addr[i]);

      // Newest source wins: write this cycle, then write during the read,
      // then the RAM data. x0 always reads as zero.
      assign load_data[i] = (s1_rs[i] == '0) ? 32'h0        :
                            wb_hit_s1[i]     ? bus.wb_wdata :
                            byp_hit[i]       ? byp_data[i]  :
                                               rdata[i];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_hart   <= '0;
      s1_tag    <= '0;
      out_valid <= 1'b0;
      out_hart  <= '0;
      out_tag   <= '0;
      for (int i = 0; i < NUM_OPND; i++) begin
        s1_rs[i]      <= '0;
        byp_hit[i]    <= 1'b0;
        byp_data[i]   <= '0;
        out_rs[i]     <= '0;
        out_data[i]   <= '0;
        raddr_last[i] <= '0;
      end
    end else begin
      // S1 occupancy
      if (accept) begin
        s1_valid <= 1'b1;
        s1_hart  <= bus.in_hart;
        s1_tag   <= bus.in_tag;
        for (int i = 0; i < NUM_OPND; i++) begin
          s1_rs[i] <= in_rs[i];
        end
      end else if (s1_move) begin
        s1_valid <= 1'b0;
      end

      for (int i = 0; i < NUM_OPND; i++) begin
        raddr_last[i] <= raddr[i];
        if (read_cycle) begin
          byp_hit[i]  <= wb_hit_rd[i];
          byp_data[i] <= bus.wb_wdata;
        end
      end

      // OUT register
      if (s1_move) begin
        out_valid <= 1'b1;
        out_hart  <= s1_hart;
        out_tag   <= s1_tag;
        for (int i = 0; i < NUM_OPND; i++) begin
          out_rs[i]   <= s1_rs[i];
          out_data[i] <= load_data[i];
        end
      end else begin
        if (bus.out_ready) begin
          out_valid <= 1'b0;
        end
        // Held operands track writes until they are consumed
        for (int i = 0; i < NUM_OPND; i++) begin
          if (out_valid && (out_rs[i] != '0) && wb_hit_out[i]) begin
            out_data[i] <= bus.wb_wdata;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready     = in_ready;
  assign bus.raddr0       = raddr[0];
  assign bus.raddr1       = raddr[1];
  assign bus.out_valid    = out_valid;
  assign bus.out_hart     = out_hart;
  assign bus.out_tag      = out_tag;
  assign bus.out_rs1_data = out_data[0];
  assign bus.out_rs2_data = out_data[1];

endmodule

`default_nettype wire

// File: tb/tb_pinwheel_operand_fetch.sv
// ============================================================================
//  Module      : tb_pinwheel_operand_fetch
//  Description : Self-checking bench for pinwheel_operand_fetch. Models the
//                registered regfile RAM, keeps a queue of accepted requests
//                and checks every cycle that the delivered operands equal the
//                register contents at the moment of the output handshake.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pinwheel_operand_fetch;

  localparam int TW = 32;
  localparam int HB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pinwheel_operand_fetch_if #(.TAG_WIDTH(TW), .HART_BITS(HB)) bus();

  pinwheel_operand_fetch #(.TAG_WIDTH(TW), .HART_BITS(HB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Regfile: registered read returning old data on same-address write,
  // writes performed even during reset.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    bus.rdata0 <= mem[bus.raddr0];
    bus.rdata1 <= mem[bus.raddr1];
    if (bus.wb_wren) mem[bus.wb_waddr] <= bus.wb_wdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: queue of requests accepted and not yet delivered
  // --------------------------------------------------------------------------
  typedef struct {
    logic [HB-1:0] hart;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [TW-1:0] tag;
    int            acc;
  } req_t;

  req_t q[$];
  int   cyc = 0;
  logic rst_seen = 1'b0;
  logic exp_v;
  logic exp_rdy;
  req_t nr;

  always @(posedge clk) begin
    cyc++;
    rst_seen <= rst;
  end

  // Operand a consumer must see right now: register contents after all
  // writes of earlier cycles, or zero for x0.
  function automatic logic [31:0] expect_op(input logic [HB-1:0] h, input logic [4:0] r);
    logic [7:0] a;
    a = {1'b0, h, r};
    return (r == 5'd0) ? 32'h0 : mem[a];
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      if (rst_seen) begin
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
        chk("rst_raddr0",    {24'b0, bus.raddr0},    32'd0);
        chk("rst_raddr1",    {24'b0, bus.raddr1},    32'd0);
        chk("rst_out_tag",   bus.out_tag,            32'd0);
        chk("rst_out_data",  bus.out_rs1_data | bus.out_rs2_data, 32'd0);
      end
    end else begin
      // An entry reaches OUT two cycles after acceptance at the earliest;
      // the oldest entry, once that old, is always the one in OUT.
      exp_v   = (q.size() > 0) && (q[0].acc <= cyc - 2);
      exp_rdy = !((q.size() == 2) && !bus.out_ready);
      chk("in_ready",  {31'b0, bus.in_ready},  {31'b0, exp_rdy});
      chk("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_v});
      if (bus.out_valid && exp_v) begin
        chk("out_hart", {30'b0, bus.out_hart}, {30'b0, q[0].hart});
        chk("out_tag",  bus.out_tag, q[0].tag);
        chk("out_rs1",  bus.out_rs1_data, expect_op(q[0].hart, q[0].rs1));
        chk("out_rs2",  bus.out_rs2_data, expect_op(q[0].hart, q[0].rs2));
      end
      if (bus.out_valid && bus.out_ready && q.size() > 0) void'(q.pop_front());
      if (bus.in_valid && bus.in_ready) begin
        nr.hart = bus.in_hart;
        nr.rs1  = bus.in_rs1;
        nr.rs2  = bus.in_rs2;
        nr.tag  = bus.in_tag;
        nr.acc  = cyc;
        q.push_back(nr);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Drivers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit v, input logic [1:0] h, input logic [4:0] a,
                         input logic [4:0] b, input logic [31:0] t);
    bus.in_valid = v;
    bus.in_hart  = h;
    bus.in_rs1   = a;
    bus.in_rs2   = b;
    bus.in_tag   = t;
  endtask

  task automatic set_wb(input bit en, input logic [7:0] a, input logic [31:0] d);
    bus.wb_wren  = en;
    bus.wb_waddr = a;
    bus.wb_wdata = d;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_wb(1'b1, a, d);
    tick();
    set_wb(1'b0, 8'h0, 32'h0);
  endtask

  task automatic drain();
    set_req(1'b0, 2'd0, 5'd0, 5'd0, 32'h0);
    set_wb(1'b0, 8'h0, 32'h0);
    bus.out_ready = 1'b1;
    repeat (4) tick();
  endtask

  // Sample DUT outputs mid-cycle and compare against a literal
  task automatic at_neg(input string name, input logic [31:0] act_sel, input logic [31:0] exp);
    chk(name, act_sel, exp);
  endtask

  initial begin
    set_req(1'b0, 2'd0, 5'd0, 5'd0, 32'h0);
    set_wb(1'b0, 8'h0, 32'h0);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    // Initialise every regfile word while the block is held in reset
    for (int a = 0; a < 256; a++) wr(8'(a), 32'hA500_0000 | 32'(a));
    rst = 1'b0;
    tick();

    // ---- 1: back-to-back accept, latency 2 ----
    wr(8'h25, 32'h1234);
    wr(8'h45, 32'hABCD);
    bus.out_ready = 1'b1;
    set_req(1'b1, 2'd1, 5'd5, 5'd5, 32'h100);
    tick();
    set_req(1'b1, 2'd2, 5'd5, 5'd5, 32'h101);
    @(negedge clk);
    at_neg("t1_not_yet_valid", {31'b0, bus.out_valid}, 32'd0);
    tick();
    set_req(1'b0, 2'd0, 5'd0, 5'd0, 32'h0);
    @(negedge clk);
    at_neg("t1_valid_t2", {31'b0, bus.out_valid}, 32'd1);
    at_neg("t1_op_t2",    bus.out_rs1_data, 32'h1234);
    at_neg("t1_tag_t2",   bus.out_tag,      32'h100);
    tick();
    @(negedge clk);
    at_neg("t1_op_t3",    bus.out_rs2_data, 32'hABCD);
    at_neg("t1_tag_t3",   bus.out_tag,      32'h101);
    drain();

    // ---- 2: x0 reads as zero, writes to x0 ignored ----
    wr(8'h00, 32'hDEAD);
    set_req(1'b1, 2'd0, 5'd0, 5'd0, 32'h200);
    set_wb(1'b1, 8'h00, 32'hBEEF);
    tick();
    set_req(1'b0, 2'd0, 5'd0, 5'd0, 32'h0);
    set_wb(1'b0, 8'h0, 32'h0);
    tick();
    @(negedge clk);
    at_neg("t2_x0_rs1", bus.out_rs1_data, 32'h0);
    at_neg("t2_x0_rs2", bus.out_rs2_data, 32'h0);
    drain();

    // ---- 3a: write in the accept cycle ----
    wr(8'h03, 32'h11);
    set_req(1'b1, 2'd0, 5'd3, 5'd3, 32'h300);
    set_wb(1'b1, 8'h03, 32'h55);
    tick();
    set_req(1'b0, 2'd0, 5'd0, 5'd0, 32'h0);
    set_wb(1'b0, 8'h0, 32'h0);
    tick();
    @(negedge clk);
    at_neg("t3a_rs1", bus.out_rs1_data, 32'h55);
    at_neg("t3a_rs2", bus.out_rs2_data, 32'h55);
    drain();
    // ---- 3b: write one cycle after accept ----
    wr(8'h03, 32'h11);
    set_req(1'b1, 2'd0, 5'd3, 5'd3, 32'h301);
    tick();
    set_req(1'b0, 2'd0, 5'd0, 5'd0, 32'h0);
    set_wb(1'b1, 8'h03, 32'h55);
    tick();
    set_wb(1'b0, 8'h0, 32'h0);
    @(negedge clk);
    at_neg("t3b_rs1", bus.out_rs1_data, 32'h55);
    drain();
    // ---- 3c: write two cycles after accept, consumed the cycle after ----
    wr(8'h03, 32'h11);
    set_req(1'b1, 2'd0, 5'd3, 5'd3, 32'h302);
    tick();
    set_req(1'b0, 2'd0, 5'd0, 5'd0, 32'h0);
    tick();
    bus.out_ready = 1'b0;
    set_wb(1'b1, 8'h03, 32'h55);
    @(negedge clk);
    at_neg("t3c_held", {31'b0, bus.out_valid}, 32'd1);
    tick();
    set_wb(1'b0, 8'h0, 32'h0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    at_neg("t3c_rs1", bus.out_rs1_data, 32'h55);
    drain();

    // ---- 4: full stall, snoop held and in-flight operands ----
    wr(8'h04, 32'h44);
    wr(8'h08, 32'h48);
    bus.out_ready = 1'b0;
    set_req(1'b1, 2'd0, 5'd4, 5'd6, 32'h400);
    tick();
    set_req(1'b1, 2'd0, 5'd8, 5'd9, 32'h401);
    tick();
    set_req(1'b0, 2'd0, 5'd0, 5'd0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      if (k == 1)      set_wb(1'b1, 8'h04, 32'h77);
      else if (k == 3) set_wb(1'b1, 8'h08, 32'h88);
      else             set_wb(1'b0, 8'h0, 32'h0);
      @(negedge clk);
      at_neg("t4_in_ready_stall", {31'b0, bus.in_ready}, 32'd0);
      tick();
    end
    set_wb(1'b0, 8'h0, 32'h0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    at_neg("t4_first_tag", bus.out_tag,      32'h400);
    at_neg("t4_held_snoop", bus.out_rs1_data, 32'h77);
    tick();
    @(negedge clk);
    at_neg("t4_second_tag", bus.out_tag,      32'h401);
    at_neg("t4_s1_snoop",   bus.out_rs1_data, 32'h88);
    tick();
    @(negedge clk);
    at_neg("t4_once", {31'b0, bus.out_valid}, 32'd0);
    drain();

    // ---- 5: hart isolation ----
    wr(8'h07, 32'h42);
    set_req(1'b1, 2'd0, 5'd7, 5'd7, 32'h500);
    set_wb(1'b1, 8'h27, 32'h99);
    tick();
    set_req(1'b0, 2'd0, 5'd0, 5'd0, 32'h0);
    set_wb(1'b0, 8'h0, 32'h0);
    tick();
    @(negedge clk);
    at_neg("t5_hart_iso", bus.out_rs1_data, 32'h42);
    drain();

    // ---- 6: reset with both stages full ----
    bus.out_ready = 1'b0;
    set_req(1'b1, 2'd1, 5'd1, 5'd2, 32'h600);
    tick();
    set_req(1'b1, 2'd2, 5'd3, 5'd4, 32'h601);
    tick();
    set_req(1'b0, 2'd0, 5'd0, 5'd0, 32'h0);
    @(negedge clk);
    at_neg("t6_full", {31'b0, bus.out_valid}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    at_neg("t6_out_valid", {31'b0, bus.out_valid}, 32'd0);
    at_neg("t6_in_ready",  {31'b0, bus.in_ready},  32'd1);
    repeat (4) tick();
    set_req(1'b1, 2'd3, 5'd5, 5'd6, 32'h602);
    tick();
    drain();

    // ---- Randomised traffic with hazards on a small register window ----
    for (int n = 0; n < 3000; n++) begin
      rst = ((n % 700) == 350);
      set_req(!rst && ($urandom_range(0, 99) < 60), 2'($urandom_range(0, 3)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom);
      bus.out_ready = ($urandom_range(0, 99) < 65);
      if ($urandom_range(0, 99) < 40)
        set_wb(1'b1, {1'b0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7))}, $urandom);
      else
        set_wb(1'b0, 8'h0, 32'h0);
      tick();
    end
    rst = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
